// File: rtl/sync_ram_read_ctrl.sv
// sync_ram_read_ctrl: read-side client for a 1-cycle synchronous RAM with write forwarding
// and a 2-entry response buffer so a stalled consumer never loses data.
module sync_ram_read_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] waddr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic                  we2_i,
  input  logic [ADDR_WIDTH-1:0] waddr2_i,
  input  logic [DATA_WIDTH-1:0] wdata2_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ADDR_WIDTH-1:0] resp_addr_o,
  output logic [DATA_WIDTH-1:0] resp_data_o
);
  logic                  r_inflight, r_fwd, r_wptr, r_rptr;
  logic [1:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [ADDR_WIDTH-1:0] r_faddr [2];
  logic [DATA_WIDTH-1:0] r_fdata [2];
  logic                  w_accept, w_empty, w_hit1, w_hit2, w_push, w_pop;
  logic [DATA_WIDTH-1:0] w_cand;

  assign ram_raddr_o  = req_addr_i;
  assign w_empty      = r_count == 2'd0;
  assign req_ready_o  = ~flush_i & (({1'b0, r_count} + {2'b0, r_inflight}) < 3'd2);
  assign w_accept     = req_valid_i & req_ready_o;
  assign w_hit1       = we1_i & (waddr1_i == req_addr_i);
  assign w_hit2       = we2_i & (waddr2_i == req_addr_i);
  assign w_cand       = r_fwd ? r_fwd_data : ram_rdata_i;
  assign resp_valid_o = ~flush_i & (~w_empty | r_inflight);
  assign resp_addr_o  = ~resp_valid_o ? '0 : w_empty ? r_addr : r_faddr[r_rptr];
  assign resp_data_o  = ~resp_valid_o ? '0 : w_empty ? w_cand : r_fdata[r_rptr];
  // The fresh read is buffered unless it bypasses straight to the consumer.
  assign w_push       = r_inflight & ~(w_empty & resp_ready_i);
  assign w_pop        = resp_valid_o & resp_ready_i & ~w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
      r_fwd      <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_addr     <= '0;
      r_fwd_data <= '0;
      for (int i = 0; i < 2; i++) begin
        r_faddr[i] <= '0;
        r_fdata[i] <= '0;
      end
    end else if (flush_i) begin
      r_inflight <= 1'b0;
      r_fwd      <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_addr     <= req_addr_i;
        r_fwd      <= w_hit1 | w_hit2;
        // Port 2 is written last by the RAM, so it wins a double hit.
        r_fwd_data <= w_hit2 ? wdata2_i : wdata1_i;
      end
      if (w_push) begin
        r_faddr[r_wptr] <= r_addr;
        r_fdata[r_wptr] <= w_cand;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_sync_ram_read_ctrl.sv
// tb_sync_ram_read_ctrl: directed stimulus with a transaction-level queue model checked every cycle.
module tb_sync_ram_read_ctrl;
  logic        clk = 0, rst_n = 0, flush = 0, req_valid = 0, resp_ready = 0;
  logic        we1 = 0, we2 = 0;
  logic [5:0]  req_addr = 0, waddr1 = 0, waddr2 = 0;
  logic [31:0] wdata1 = 0, wdata2 = 0, ram_rdata = 0;
  logic        req_ready, resp_valid;
  logic [5:0]  ram_raddr, resp_addr;
  logic [31:0] resp_data;
  logic [31:0] mem [64];
  int checks = 0, errors = 0;

  typedef struct {logic [5:0] a; logic [31:0] d;} rsp_t;
  rsp_t q[$];

  sync_ram_read_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .we2_i(we2), .waddr2_i(waddr2), .wdata2_i(wdata2),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_addr_o(resp_addr), .resp_data_o(resp_data));

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | i;

  // RAM stub: registered read of the pre-write contents, port 2 written after port 1.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  // Model: the outstanding-response queue; a response carries memory as seen after this cycle's writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (flush) q.delete();
    else begin
      automatic bit acc = req_valid && q.size() < 2;
      automatic bit fire = resp_ready && q.size() > 0;
      automatic rsp_t r;
      r.a = req_addr;
      r.d = mem[req_addr];
      if (we1 && waddr1 == req_addr) r.d = wdata1;
      if (we2 && waddr2 == req_addr) r.d = wdata2;
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(r);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic bit ev = !flush && q.size() > 0;
    chk("ram_raddr", {26'b0, ram_raddr}, {26'b0, req_addr});
    chk("req_ready", {31'b0, req_ready}, {31'b0, !flush && q.size() < 2});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
    chk("resp_addr", {26'b0, resp_addr}, ev ? {26'b0, q[0].a} : 32'd0);
    chk("resp_data", resp_data, ev ? q[0].d : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_data", resp_data, 32'd0);
    rst_n = 1;
    tick();
    // 1: plain read
    resp_ready = 1; req_valid = 1; req_addr = 5;
    tick();
    req_valid = 0;
    @(negedge clk);
    chk("t1_valid", {31'b0, resp_valid}, 32'd1);
    chk("t1_data", resp_data, 32'hA5A5_0005);
    chk("t1_addr", {26'b0, resp_addr}, 32'd5);
    tick();
    // 2: forward from port 1, later write ignored
    req_valid = 1; req_addr = 7; we1 = 1; waddr1 = 7; wdata1 = 32'h1111;
    tick();
    req_valid = 0; wdata1 = 32'h9999;
    @(negedge clk);
    chk("t2_data", resp_data, 32'h1111);
    tick();
    we1 = 0;
    // 3: double hit, port 2 wins
    req_valid = 1; req_addr = 7; we1 = 1; waddr1 = 7; wdata1 = 32'h1111;
    we2 = 1; waddr2 = 7; wdata2 = 32'h2222;
    tick();
    req_valid = 0; we1 = 0; we2 = 0;
    @(negedge clk);
    chk("t3_data", resp_data, 32'h2222);
    tick();
    // 4: back-pressure
    resp_ready = 0; req_valid = 1; req_addr = 1;
    tick();
    req_addr = 2;
    tick();
    req_addr = 3;
    tick();
    tick();
    @(negedge clk);
    chk("t4_ready", {31'b0, req_ready}, 32'd0);
    chk("t4_head", resp_data, 32'hA5A5_0001);
    resp_ready = 1;
    tick();
    @(negedge clk);
    chk("t4_second", resp_data, 32'hA5A5_0002);
    chk("t4_ready_back", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 0;
    @(negedge clk);
    chk("t4_third", resp_data, 32'hA5A5_0003);
    tick();
    // 5: streaming
    for (int i = 0; i < 16; i++) begin
      req_valid = 1; req_addr = 6'(i);
      tick();
    end
    req_valid = 0;
    tick();
    // 6: flush with two outstanding
    resp_ready = 0; req_valid = 1; req_addr = 10;
    tick();
    req_addr = 11;
    tick();
    req_addr = 12; flush = 1;
    @(negedge clk);
    chk("t6_flush_valid", {31'b0, resp_valid}, 32'd0);
    chk("t6_flush_ready", {31'b0, req_ready}, 32'd0);
    tick();
    flush = 0; req_valid = 0;
    @(negedge clk);
    chk("t6_after_valid", {31'b0, resp_valid}, 32'd0);
    tick();
    req_valid = 1; req_addr = 9; resp_ready = 1;
    tick();
    req_valid = 0;
    @(negedge clk);
    chk("t6_next_data", resp_data, 32'hA5A5_0009);
    tick();
    // async reset mid-transaction
    req_valid = 1; req_addr = 4;
    tick();
    req_valid = 0; rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, resp_valid}, 32'd0);
    chk("arst_ready", {31'b0, req_ready}, 32'd1);
    tick();
    rst_n = 1;
    tick();
    req_valid = 1; req_addr = 0;
    tick();
    req_valid = 0;
    @(negedge clk);
    chk("arst_next", resp_data, 32'hA5A5_0000);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
